// File: rtl/vedic_mult_pipe_pkg.sv
// Shared sizing helpers for the Vedic multiplier slice; no logic, no latency.
// Width legality is checked where WIDTH is known (top-level elaboration).
package vedic_pkg;

    localparam int VEDIC_MIN_WIDTH = 4;

    function automatic int prod_width(input int w);
        return 2 * w;
    endfunction

    function automatic int half_width(input int w);
        return w / 2;
    endfunction

    function automatic bit width_ok(input int w);
        return (w >= VEDIC_MIN_WIDTH) && ((w % 2) == 0);
    endfunction

endpackage

// File: rtl/vedic_mult_pipe_if.sv
// Operand/product handshake bundle for vedic_mult_pipe; is_signed exists only
// with VEDIC_MULT_SIGNED_EN. Valid/ready on both sides, no buffering here.
interface vedic_mult_pipe_if
    import vedic_pkg::*;
#(
    parameter int WIDTH = 8
);
    logic                         in_valid;
    logic                         in_ready;
    logic [WIDTH-1:0]             a;
    logic [WIDTH-1:0]             b;
`ifdef VEDIC_MULT_SIGNED_EN
    logic                         is_signed;
`endif
    logic                         out_valid;
    logic                         out_ready;
    logic [prod_width(WIDTH)-1:0] p;

`ifdef VEDIC_MULT_SIGNED_EN
    modport master (output in_valid, a, b, is_signed, out_ready,
                    input  in_ready, out_valid, p);
    modport slave  (input  in_valid, a, b, is_signed, out_ready,
                    output in_ready, out_valid, p);
`else
    modport master (output in_valid, a, b, out_ready,
                    input  in_ready, out_valid, p);
    modport slave  (input  in_valid, a, b, out_ready,
                    output in_ready, out_valid, p);
`endif
endinterface

// File: rtl/vedic_mult_pipe_half.sv
// Unsigned H x H -> 2H partial-product multiplier.
// Purely combinational; no handshake.
module vedic_mult_half
    import vedic_pkg::*;
#(
    parameter int H = 4
)
(
    input  logic [H-1:0]             x,
    input  logic [H-1:0]             y,
    output logic [prod_width(H)-1:0] z
);
    assign z = {{H{1'b0}}, x} * {{H{1'b0}}, y};
endmodule

// File: rtl/vedic_mult_pipe.sv
// Two-stage pipelined half-split multiplier; VEDIC_MULT_SIGNED_EN adds is_signed.
// Latency 2 cycles, one product per cycle; at most two products in flight.
// Full backpressure: a held, unconsumed product freezes both stages and drops in_ready.
module vedic_mult_pipe
    import vedic_pkg::*;
#(
    parameter int WIDTH = 8
)
(
    input  logic             clk,
    input  logic             rst,
    vedic_mult_pipe_if.slave bus
);
    localparam int H  = half_width(WIDTH);
    localparam int PW = prod_width(WIDTH);

    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("vedic_mult_pipe: WIDTH must be even and at least 4");
    end

    logic          stall;
    logic [PW-1:0] p_q;
    logic          out_valid_q;
    logic          valid_s1;
    logic [2*H-1:0] ll_c, hl_c, lh_c, hh_c;
    logic [2*H-1:0] ll_q, hl_q, lh_q, hh_q;
    logic [PW-1:0] mid_c;
    logic [PW-1:0] sum_c;

    assign stall         = out_valid_q && !bus.out_ready;
    assign bus.in_ready  = !stall;
    assign bus.out_valid = out_valid_q;
    assign bus.p         = p_q;

    vedic_mult_half #(.H(H)) u_ll (.x(bus.a[H-1:0]),     .y(bus.b[H-1:0]),     .z(ll_c));
    vedic_mult_half #(.H(H)) u_hl (.x(bus.a[WIDTH-1:H]), .y(bus.b[H-1:0]),     .z(hl_c));
    vedic_mult_half #(.H(H)) u_lh (.x(bus.a[H-1:0]),     .y(bus.b[WIDTH-1:H]), .z(lh_c));
    vedic_mult_half #(.H(H)) u_hh (.x(bus.a[WIDTH-1:H]), .y(bus.b[WIDTH-1:H]), .z(hh_c));

`ifdef VEDIC_MULT_SIGNED_EN
    // Two's-complement fix-up: each negative operand contributes other << WIDTH.
    logic [PW-1:0] corr_c;
    logic [PW-1:0] corr_q;

    always_comb begin
        corr_c = '0;
        if (bus.is_signed) begin
            if (bus.a[WIDTH-1]) corr_c = corr_c + (PW'(bus.b) << WIDTH);
            if (bus.b[WIDTH-1]) corr_c = corr_c + (PW'(bus.a) << WIDTH);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            corr_q <= '0;
        end else if (!stall) begin
            corr_q <= corr_c;
        end
    end
`endif

    assign mid_c = PW'(hl_q) + PW'(lh_q);

`ifdef VEDIC_MULT_SIGNED_EN
    assign sum_c = PW'(ll_q) + (mid_c << H) + (PW'(hh_q) << WIDTH) - corr_q;
`else
    assign sum_c = PW'(ll_q) + (mid_c << H) + (PW'(hh_q) << WIDTH);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_s1    <= 1'b0;
            ll_q        <= '0;
            hl_q        <= '0;
            lh_q        <= '0;
            hh_q        <= '0;
            out_valid_q <= 1'b0;
            p_q         <= '0;
        end else if (!stall) begin
            valid_s1    <= bus.in_valid;
            ll_q        <= ll_c;
            hl_q        <= hl_c;
            lh_q        <= lh_c;
            hh_q        <= hh_c;
            out_valid_q <= valid_s1;
            p_q         <= sum_c;
        end
    end
endmodule

// File: tb/tb_vedic_mult_pipe.sv
// Bench for vedic_mult_pipe at WIDTH=8 and WIDTH=16 with queue scoreboards.
module tb_vedic_mult_pipe;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vedic_mult_pipe_if #(.WIDTH(8))  b8 ();
    vedic_mult_pipe_if #(.WIDTH(16)) b16 ();

    vedic_mult_pipe #(.WIDTH(8))  u8  (.clk(clk), .rst(rst), .bus(b8.slave));
    vedic_mult_pipe #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .bus(b16.slave));

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sgn;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] exp;
        int          t;
        int          st;
    } sb_t;

    sb_t q8[$];
    sb_t q16[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int st8 = 0;
    int st16 = 0;
    logic [15:0] pend8;
    logic [31:0] pend16;

    always @(posedge clk) cyc++;

    function automatic logic [31:0] model(input int w, input logic [15:0] a,
                                          input logic [15:0] b, input logic sgn);
        longint sa, sb, m, r;
        m  = (w == 8) ? 64'd256 : 64'd65536;
        sa = (w == 8) ? longint'(a[7:0]) : longint'(a);
        sb = (w == 8) ? longint'(b[7:0]) : longint'(b);
        if (sgn && sa >= m / 2) sa = sa - m;
        if (sgn && sb >= m / 2) sb = sb - m;
        r = (sa * sb) & (m * m - 1);
        return r[31:0];
    endfunction

    always @(negedge clk) begin
        sb_t e;
        if (rst) begin
            q8.delete();
        end else begin
            if (b8.out_valid && b8.out_ready) begin
                checks++;
                if (q8.size() == 0) begin
                    errors++;
                    $display("FAIL out8_spurious: p=%h emitted with nothing pending", b8.p);
                end else begin
                    e = q8.pop_front();
                    if (b8.p !== e.exp[15:0]) begin
                        errors++;
                        $display("FAIL out8_value: got %h expected %h", b8.p, e.exp[15:0]);
                    end
                    checks++;
                    if (cyc - e.t != 2 + (st8 - e.st)) begin
                        errors++;
                        $display("FAIL out8_latency: got %0d expected %0d", cyc - e.t, 2 + (st8 - e.st));
                    end
                end
            end
            if (b8.out_valid && !b8.out_ready) st8++;
            if (b8.in_valid && b8.in_ready) q8.push_back('{{16'h0, pend8}, cyc, st8});
        end
    end

    always @(negedge clk) begin
        sb_t e;
        if (rst) begin
            q16.delete();
        end else begin
            if (b16.out_valid && b16.out_ready) begin
                checks++;
                if (q16.size() == 0) begin
                    errors++;
                    $display("FAIL out16_spurious: p=%h emitted with nothing pending", b16.p);
                end else begin
                    e = q16.pop_front();
                    if (b16.p !== e.exp) begin
                        errors++;
                        $display("FAIL out16_value: got %h expected %h", b16.p, e.exp);
                    end
                    checks++;
                    if (cyc - e.t != 2 + (st16 - e.st)) begin
                        errors++;
                        $display("FAIL out16_latency: got %0d expected %0d", cyc - e.t, 2 + (st16 - e.st));
                    end
                end
            end
            if (b16.out_valid && !b16.out_ready) st16++;
            if (b16.in_valid && b16.in_ready) q16.push_back('{pend16, cyc, st16});
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic sgn,
                         input logic [15:0] exp);
        bit ok;
        ok = 1'b0;
        pend8 = exp;
        b8.a = a;
        b8.b = b;
`ifdef VEDIC_MULT_SIGNED_EN
        b8.is_signed = sgn;
`endif
        b8.in_valid = 1'b1;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            ok = b8.in_ready;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send8_timeout: in_ready=0 expected 1 within 100 cycles (sgn=%b)", sgn);
        end
        @(posedge clk);
        #1;
        b8.in_valid = 1'b0;
    endtask

    task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic sgn,
                          input logic [31:0] exp);
        bit ok;
        ok = 1'b0;
        pend16 = exp;
        b16.a = a;
        b16.b = b;
`ifdef VEDIC_MULT_SIGNED_EN
        b16.is_signed = sgn;
`endif
        b16.in_valid = 1'b1;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            ok = b16.in_ready;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send16_timeout: in_ready=0 expected 1 within 100 cycles (sgn=%b)", sgn);
        end
        @(posedge clk);
        #1;
        b16.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t t8[$];
        vec_t t16[$];
        bit   done;
        logic [15:0] ra, rb;
        logic rs;

        t8.push_back('{16'h00FF, 16'h00FF, 1'b0, 32'h0000FE01});
        t8.push_back('{16'h000F, 16'h00F0, 1'b0, 32'h00000E10});
        t8.push_back('{16'h0000, 16'h00AB, 1'b0, 32'h00000000});
        t8.push_back('{16'h0080, 16'h007F, 1'b0, 32'h00003F80});
        t8.push_back('{16'h0012, 16'h0034, 1'b0, 32'h000003A8});
`ifdef VEDIC_MULT_SIGNED_EN
        t8.push_back('{16'h00FF, 16'h00FF, 1'b1, 32'h00000001});
        t8.push_back('{16'h0080, 16'h007F, 1'b1, 32'h0000C080});
        t8.push_back('{16'h0080, 16'h0080, 1'b1, 32'h00004000});
`endif
        t16.push_back('{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001});
        t16.push_back('{16'h1234, 16'h5678, 1'b0, 32'h06260060});

        rst = 1'b1;
        b8.in_valid = 1'b0;  b8.a = '0;  b8.b = '0;  b8.out_ready = 1'b1;
        b16.in_valid = 1'b0; b16.a = '0; b16.b = '0; b16.out_ready = 1'b1;
`ifdef VEDIC_MULT_SIGNED_EN
        b8.is_signed = 1'b0;
        b16.is_signed = 1'b0;
`endif
        pend8 = '0;
        pend16 = '0;
        idle(3);
        rst = 1'b0;

        @(negedge clk);
        check("reset_out_valid8", 32'(b8.out_valid), 32'h0);
        check("reset_p8", 32'(b8.p), 32'h0);
        check("reset_in_ready8", 32'(b8.in_ready), 32'h1);
        check("reset_out_valid16", 32'(b16.out_valid), 32'h0);
        check("reset_p16", b16.p, 32'h0);
        idle(1);

        // back-to-back table vectors, consumer always ready
        foreach (t8[i]) send8(t8[i].a[7:0], t8[i].b[7:0], t8[i].sgn, t8[i].exp[15:0]);
        foreach (t16[i]) send16(t16[i].a, t16[i].b, t16[i].sgn, t16[i].exp);
        idle(5);

        // backpressure: first product held for 4 cycles, third waits at the input
        send8(8'h11, 8'h11, 1'b0, 16'h0121);
        b8.out_ready = 1'b0;
        send8(8'h22, 8'h03, 1'b0, 16'h0066);
        fork
            send8(8'hFE, 8'h02, 1'b0, 16'h01FC);
            begin
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    check("stall_p", 32'(b8.p), 32'h0121);
                    check("stall_out_valid", 32'(b8.out_valid), 32'h1);
                    check("stall_in_ready", 32'(b8.in_ready), 32'h0);
                end
                @(posedge clk);
                #1;
                b8.out_ready = 1'b1;
            end
        join
        idle(6);

        // reset with two products in flight
        send8(8'h55, 8'h66, 1'b0, 16'h21DE);
        send8(8'h77, 8'h88, 1'b0, 16'h3F38);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        @(negedge clk);
        check("midreset_out_valid", 32'(b8.out_valid), 32'h0);
        check("midreset_p", 32'(b8.p), 32'h0);
        check("midreset_in_ready", 32'(b8.in_ready), 32'h1);
        idle(6);
        send8(8'h03, 8'h05, 1'b0, 16'h000F);
        idle(4);

        // random traffic with a randomly stalling consumer
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    ra = 16'($urandom);
                    rb = 16'($urandom);
`ifdef VEDIC_MULT_SIGNED_EN
                    rs = 1'($urandom_range(0, 1));
`else
                    rs = 1'b0;
`endif
                    send8(ra[7:0], rb[7:0], rs, model(8, ra, rb, rs)[15:0]);
                    send16(ra, rb, rs, model(16, ra, rb, rs));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    b8.out_ready = ($urandom_range(0, 3) != 0);
                    b16.out_ready = ($urandom_range(0, 3) != 0);
                end
                b8.out_ready = 1'b1;
                b16.out_ready = 1'b1;
            end
        join

        for (int k = 0; k < 50 && (q8.size() != 0 || q16.size() != 0); k++) idle(1);
        check("drain_q8", 32'(q8.size()), 32'h0);
        check("drain_q16", 32'(q16.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
